// File: rtl/ula_pkg.sv
// Shared encodings for the ULA stimulus driver: driver FSM states, command steps,
// the ULA's own state codes, opcodes and display-base codes.
package ula_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PRESS,
        ST_RELEASE,
        ST_CLR_PRESS,
        ST_CLR_GAP
    } drv_state_t;

    typedef enum logic [1:0] {
        STEP_WRAP,
        STEP_A,
        STEP_B,
        STEP_OP
    } step_t;

    typedef enum logic [1:0] {
        ULA_A      = 2'b00,
        ULA_B      = 2'b01,
        ULA_OP     = 2'b10,
        ULA_RESULT = 2'b11
    } ula_state_t;

    typedef enum logic [2:0] {
        OP_SOMA = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_XOR  = 3'b100,
        OP_NAND = 3'b101,
        OP_NOR  = 3'b110,
        OP_NOT  = 3'b111
    } opcode_t;

    typedef enum logic [1:0] {
        EXIB_OCT = 2'b00,
        EXIB_HEX = 2'b01,
        EXIB_DEC = 2'b10
    } exib_t;

    // The wrap press only has to move the ULA out of RESULT, so it reuses operand A.
    function automatic logic [7:0] step_sw(step_t step, logic [7:0] a, logic [7:0] b,
                                           logic [2:0] op);
        case (step)
            STEP_WRAP, STEP_A: step_sw = a;
            STEP_B:            step_sw = b;
            default:           step_sw = {op, 5'b00000};
        endcase
    endfunction

endpackage

// File: rtl/press_timer.sv
// Hold counter for the stimulus driver: cleared by load, flags the last cycle of a
// state whose length is given by limit (a limit of 0 behaves as 1).
module press_timer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [23:0] limit,
    output logic        tc
);

    logic [23:0] count;
    logic [23:0] last;

    assign last = (limit == 24'd0) ? 24'd0 : limit - 24'd1;
    assign tc   = (count == last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (load)
            count <= '0;
        else
            count <= count + 24'd1;
    end

endmodule

// File: rtl/ula_stimulus_driver.sv
// Drives a board-level ULA through its switch/button interface: each command is
// replayed as a series of debounced KEY[0] presses with SW/Exib held steady.
module ula_stimulus_driver
    import ula_pkg::*;
#(
    parameter logic [23:0] SETTLE_CYCLES = 24'd1000,
    parameter logic [23:0] PRESS_CYCLES  = 24'd1_500_000,
    parameter logic [23:0] GAP_CYCLES    = 24'd1_500_000
) (
    input  logic       CLOCK_50,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_a,
    input  logic [7:0] cmd_b,
    input  logic [2:0] cmd_op,
    input  logic [1:0] cmd_exib,
    input  logic       clr_req,
    output logic [7:0] SW,
    output logic [1:0] KEY,
    output logic [1:0] Exib,
    output logic       busy,
    output logic       done,
    output logic [1:0] ula_state
);

    drv_state_t state;
    step_t      step;
    ula_state_t ula_q;
    logic [7:0] a_q;
    logic [7:0] b_q;
    logic [2:0] op_q;
    logic [23:0] limit;
    logic        load;
    logic        tc;

    always_comb begin
        limit = SETTLE_CYCLES;
        case (state)
            ST_PRESS, ST_CLR_PRESS: limit = PRESS_CYCLES;
            ST_RELEASE, ST_CLR_GAP: limit = GAP_CYCLES;
            default:                limit = SETTLE_CYCLES;
        endcase
    end

    // Every non-idle state leaves on terminal count, so tc doubles as the entry reload.
    assign load      = (state == ST_IDLE) || tc;
    assign cmd_ready = (state == ST_IDLE) && !clr_req;
    assign ula_state = ula_q;

    press_timer u_timer (
        .clk  (CLOCK_50),
        .rst_n(rst_n),
        .load (load),
        .limit(limit),
        .tc   (tc)
    );

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            step  <= STEP_A;
            ula_q <= ULA_A;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            SW    <= '0;
            Exib  <= '0;
            KEY   <= 2'b11;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (clr_req) begin
                        state <= ST_CLR_PRESS;
                        KEY   <= 2'b01;
                        busy  <= 1'b1;
                    end else if (cmd_valid) begin
                        a_q   <= cmd_a;
                        b_q   <= cmd_b;
                        op_q  <= cmd_op;
                        SW    <= cmd_a;
                        Exib  <= cmd_exib;
                        step  <= (ula_q == ULA_RESULT) ? STEP_WRAP : STEP_A;
                        state <= ST_SETUP;
                        busy  <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    if (tc) begin
                        state <= ST_PRESS;
                        KEY   <= 2'b10;
                    end
                end
                ST_PRESS: begin
                    if (tc) begin
                        state <= ST_RELEASE;
                        KEY   <= 2'b11;
                        ula_q <= ula_state_t'(ula_q + 2'd1);
                    end
                end
                ST_RELEASE: begin
                    if (tc) begin
                        if (step == STEP_OP) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            step  <= step_t'(step + 2'd1);
                            SW    <= step_sw(step_t'(step + 2'd1), a_q, b_q, op_q);
                            state <= ST_SETUP;
                        end
                    end
                end
                ST_CLR_PRESS: begin
                    if (tc) begin
                        state <= ST_CLR_GAP;
                        KEY   <= 2'b11;
                    end
                end
                ST_CLR_GAP: begin
                    if (tc) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        ula_q <= ULA_A;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    KEY   <= 2'b11;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ula_stimulus_driver.sv
// Self-checking bench for ula_stimulus_driver: table of directed commands, random
// commands against a step/phase timeline model, clear, reset mid-press, zero params.
module tb_ula_stimulus_driver;

    localparam int S = 2;
    localparam int P = 4;
    localparam int G = 3;
    localparam int T = S + P + G;

    logic       CLOCK_50 = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic [2:0] cmd_op;
    logic [1:0] cmd_exib;
    logic       clr_req;
    logic [7:0] SW;
    logic [1:0] KEY;
    logic [1:0] Exib;
    logic       busy;
    logic       done;
    logic [1:0] ula_state;

    logic       valid_z;
    logic       zero_clr;
    logic       ready_z;
    logic [7:0] sw_z;
    logic [1:0] key_z;
    logic [1:0] exib_z;
    logic       busy_z;
    logic       done_z;
    logic [1:0] ula_z;

    int num_checks = 0;
    int num_fail   = 0;
    int mdl_ula;
    logic [7:0] mdl_sw;
    logic [1:0] mdl_exib;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic [1:0] exib;
        logic       clr_in_b;
        int         done_cyc;
        logic [7:0] op_sw;
    } cmd_vec_t;

    cmd_vec_t vectors[4];

    always #5 CLOCK_50 = ~CLOCK_50;

    ula_stimulus_driver #(
        .SETTLE_CYCLES(24'd2),
        .PRESS_CYCLES (24'd4),
        .GAP_CYCLES   (24'd3)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_a    (cmd_a),
        .cmd_b    (cmd_b),
        .cmd_op   (cmd_op),
        .cmd_exib (cmd_exib),
        .clr_req  (clr_req),
        .SW       (SW),
        .KEY      (KEY),
        .Exib     (Exib),
        .busy     (busy),
        .done     (done),
        .ula_state(ula_state)
    );

    ula_stimulus_driver #(
        .SETTLE_CYCLES(24'd0),
        .PRESS_CYCLES (24'd0),
        .GAP_CYCLES   (24'd0)
    ) dut_zero (
        .CLOCK_50 (CLOCK_50),
        .rst_n    (rst_n),
        .cmd_valid(valid_z),
        .cmd_ready(ready_z),
        .cmd_a    (cmd_a),
        .cmd_b    (cmd_b),
        .cmd_op   (cmd_op),
        .cmd_exib (cmd_exib),
        .clr_req  (zero_clr),
        .SW       (sw_z),
        .KEY      (key_z),
        .Exib     (exib_z),
        .busy     (busy_z),
        .done     (done_z),
        .ula_state(ula_z)
    );

    task automatic checkOutput(input string name, input int act, input int exp);
        num_checks++;
        if (act !== exp) begin
            num_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [7:0] a, input logic [7:0] b,
                                 input logic [2:0] op, input logic [1:0] ex, input logic clr);
        cmd_valid = valid;
        cmd_a     = a;
        cmd_b     = b;
        cmd_op    = op;
        cmd_exib  = ex;
        clr_req   = clr;
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    function automatic logic [16:0] observe();
        return {SW, Exib, KEY, busy, done, cmd_ready, ula_state};
    endfunction

    // Both buttons low at once would put the ULA into an undefined combination.
    always @(negedge CLOCK_50)
        checkOutput("keys_exclusive", int'(KEY == 2'b00), 0);

    // Timeline model: a command is a list of steps, each S settle + P press + G gap cycles.
    task automatic runCommand(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                              input logic [1:0] ex, input logic clr_in_b,
                              output int done_cyc, output logic [7:0] op_sw);
        int nsteps, total, start, k, ph, presses, clr_at;
        logic [7:0] sws[4];
        logic [7:0] esw;
        logic [1:0] ekey, eula;
        logic ebusy, edone, eready;
        start  = mdl_ula;
        nsteps = (start == 3) ? 4 : 3;
        if (nsteps == 4) begin
            sws[0] = a; sws[1] = a; sws[2] = b; sws[3] = {op, 5'b0};
        end else begin
            sws[0] = a; sws[1] = b; sws[2] = {op, 5'b0}; sws[3] = 8'h00;
        end
        total    = nsteps * T;
        clr_at   = clr_in_b ? (nsteps - 2) * T + S + 2 : -1;
        done_cyc = 0;
        op_sw    = 8'h00;
        applyStimulus(1'b1, a, b, op, ex, 1'b0);
        #1;
        checkOutput("ready_at_accept", int'(cmd_ready), 1);
        for (int c = 1; c <= total + 2; c++) begin
            tick();
            if (c <= total) begin
                k      = (c - 1) / T;
                ph     = (c - 1) % T;
                esw    = sws[k];
                ekey   = (ph >= S && ph < S + P) ? 2'b10 : 2'b11;
                ebusy  = 1'b1;
                edone  = 1'b0;
                eready = 1'b0;
            end else begin
                esw    = sws[nsteps-1];
                ekey   = 2'b11;
                ebusy  = 1'b0;
                edone  = (c == total + 1);
                eready = 1'b1;
            end
            presses = 0;
            for (int j = 0; j < nsteps; j++)
                if (c - 1 >= j * T + S + P) presses++;
            eula = 2'((start + presses) % 4);
            checkOutput($sformatf("cmd_cycle_%0d", c), int'(observe()),
                        int'({esw, ex, ekey, ebusy, edone, eready, eula}));
            if (done && done_cyc == 0) done_cyc = c;
            if (c == (nsteps - 1) * T + S + 1) op_sw = SW;
            applyStimulus(1'b0, 8'($urandom), 8'($urandom), 3'($urandom), 2'($urandom),
                          c == clr_at);
        end
        applyStimulus(1'b0, 8'h00, 8'h00, 3'b000, 2'b00, 1'b0);
        mdl_ula  = 3;
        mdl_sw   = {op, 5'b0};
        mdl_exib = ex;
    endtask

    task automatic runClear();
        int key1_low, key0_low, done_cyc;
        logic [1:0] ekey;
        logic ebusy, edone;
        key1_low = 0;
        key0_low = 0;
        done_cyc = 0;
        applyStimulus(1'b1, 8'h77, 8'h11, 3'b010, 2'b01, 1'b1);
        #1;
        checkOutput("ready_with_clr", int'(cmd_ready), 0);
        for (int c = 1; c <= P + G + 2; c++) begin
            tick();
            ekey  = (c <= P) ? 2'b01 : 2'b11;
            ebusy = (c <= P + G);
            edone = (c == P + G + 1);
            checkOutput($sformatf("clr_cycle_%0d", c), int'(observe()),
                        int'({mdl_sw, mdl_exib, ekey, ebusy, edone, !ebusy,
                              ebusy ? 2'(mdl_ula) : 2'b00}));
            if (!KEY[1]) key1_low++;
            if (!KEY[0]) key0_low++;
            if (done && done_cyc == 0) done_cyc = c;
            applyStimulus(1'b0, 8'h00, 8'h00, 3'b000, 2'b00, 1'b0);
        end
        checkOutput("clr_key1_low_cycles", key1_low, P);
        checkOutput("clr_key0_low_cycles", key0_low, 0);
        checkOutput("clr_done_cycle", done_cyc, P + G + 1);
        mdl_ula = 0;
    endtask

    task automatic runResetMidPress();
        int done_seen;
        done_seen = 0;
        applyStimulus(1'b1, 8'h3C, 8'hC3, 3'b100, 2'b01, 1'b0);
        tick();
        applyStimulus(1'b0, 8'h00, 8'h00, 3'b000, 2'b00, 1'b0);
        for (int c = 2; c <= T + S + 2; c++) tick();
        checkOutput("key0_low_before_reset", int'(KEY), 2'b10);
        rst_n = 1'b0;
        #1;
        checkOutput("reset_mid_press", int'(observe()),
                    int'({8'h00, 2'b00, 2'b11, 1'b0, 1'b0, 1'b1, 2'b00}));
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 2 * T; c++) begin
            tick();
            if (done) done_seen++;
        end
        checkOutput("no_done_after_reset", done_seen, 0);
        checkOutput("ready_after_reset", int'(cmd_ready), 1);
        mdl_ula  = 0;
        mdl_sw   = 8'h00;
        mdl_exib = 2'b00;
    endtask

    task automatic runZeroParams();
        int fall_cyc, done_cyc;
        fall_cyc = 0;
        done_cyc = 0;
        applyStimulus(1'b0, 8'h21, 8'h12, 3'b101, 2'b10, 1'b0);
        valid_z = 1'b1;
        tick();
        valid_z = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (!key_z[0] && fall_cyc == 0) fall_cyc = c;
            if (done_z && done_cyc == 0) done_cyc = c;
            tick();
        end
        checkOutput("zero_first_fall", fall_cyc, 2);
        checkOutput("zero_done_cycle", done_cyc, 10);
        checkOutput("zero_final", int'({sw_z, exib_z, busy_z, ready_z, ula_z}),
                    int'({8'hA0, 2'b10, 1'b0, 1'b1, 2'b11}));
    endtask

    initial begin
        int done_cyc, exp_done;
        logic [7:0] op_sw;
        logic [7:0] ra, rb;
        logic [2:0] rop;
        logic [1:0] rex;
        logic       rclr;

        vectors[0] = '{a: 8'h05, b: 8'h03, op: 3'b000, exib: 2'b00, clr_in_b: 1'b0,
                       done_cyc: 28, op_sw: 8'h00};
        vectors[1] = '{a: 8'h10, b: 8'h02, op: 3'b001, exib: 2'b01, clr_in_b: 1'b0,
                       done_cyc: 37, op_sw: 8'h20};
        vectors[2] = '{a: 8'h7E, b: 8'h81, op: 3'b110, exib: 2'b10, clr_in_b: 1'b0,
                       done_cyc: 37, op_sw: 8'hC0};
        vectors[3] = '{a: 8'h5A, b: 8'hA5, op: 3'b011, exib: 2'b01, clr_in_b: 1'b1,
                       done_cyc: 37, op_sw: 8'h60};

        rst_n    = 1'b0;
        valid_z  = 1'b0;
        zero_clr = 1'b0;
        applyStimulus(1'b0, 8'h00, 8'h00, 3'b000, 2'b00, 1'b0);
        repeat (3) tick();
        checkOutput("reset_state", int'(observe()),
                    int'({8'h00, 2'b00, 2'b11, 1'b0, 1'b0, 1'b1, 2'b00}));
        rst_n = 1'b1;
        tick();
        mdl_ula  = 0;
        mdl_sw   = 8'h00;
        mdl_exib = 2'b00;

        for (int i = 0; i < 4; i++) begin
            runCommand(vectors[i].a, vectors[i].b, vectors[i].op, vectors[i].exib,
                       vectors[i].clr_in_b, done_cyc, op_sw);
            checkOutput($sformatf("vec%0d_done_cycle", i), done_cyc, vectors[i].done_cyc);
            checkOutput($sformatf("vec%0d_op_sw", i), int'(op_sw), int'(vectors[i].op_sw));
            checkOutput($sformatf("vec%0d_exib", i), int'(Exib), int'(vectors[i].exib));
        end

        runClear();

        for (int i = 0; i < 4; i++) begin
            ra       = 8'($urandom);
            rb       = 8'($urandom);
            rop      = 3'($urandom);
            rex      = 2'($urandom_range(0, 2));
            rclr     = 1'($urandom);
            exp_done = ((mdl_ula == 3) ? 4 : 3) * T + 1;
            runCommand(ra, rb, rop, rex, rclr, done_cyc, op_sw);
            checkOutput($sformatf("rand%0d_done_cycle", i), done_cyc, exp_done);
            checkOutput($sformatf("rand%0d_op_sw", i), int'(op_sw), int'({rop, 5'b0}));
        end

        runResetMidPress();

        runCommand(8'h05, 8'h03, 3'b000, 2'b00, 1'b0, done_cyc, op_sw);
        checkOutput("recovery_done_cycle", done_cyc, 3 * T + 1);

        runZeroParams();

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
        $finish;
    end

endmodule

// File: doc/ula_stimulus_driver.md
ULA_STIMULUS_DRIVER -- requirements
Module: ula_stimulus_driver

Interface
REQ-001 Parameter SETTLE_CYCLES, default 24'd1000, SW/Exib hold time before each press.
REQ-002 Parameter PRESS_CYCLES, default 24'd1_500_000, KEY low duration; exceeds the debounce filter window.
REQ-003 Parameter GAP_CYCLES, default 24'd1_500_000, KEY high duration after each release.
REQ-004 CLOCK_50 input 1, the single clock; all logic on its rising edge.
REQ-005 rst_n input 1, reset, asynchronous, active-low.
REQ-006 cmd_valid input 1, command request.
REQ-007 cmd_ready output 1, driver can accept a command.
REQ-008 cmd_a, cmd_b input 8 each, operands.
REQ-009 cmd_op input 3, ALU opcode.
REQ-010 cmd_exib input 2, display base: 00 octal, 01 hex, 10 decimal.
REQ-011 clr_req input 1, request for a ULA reset press.
REQ-012 SW output 8, drives the ULA switch bus.
REQ-013 KEY output 2, active-low buttons: KEY[0] advances the ULA state, KEY[1] resets it.
REQ-014 Exib output 2, drives the ULA display-select switches.
REQ-015 busy output 1, a sequence is in progress.
REQ-016 done output 1, one-cycle pulse when a command or clear completes.
REQ-017 ula_state output 2, the driver's model of the ULA state counter.

Function
REQ-018 FSM states: IDLE, SETUP (SW stable, counts SETTLE_CYCLES), PRESS (KEY[0]=0, counts PRESS_CYCLES), RELEASE (KEY[0]=1, counts GAP_CYCLES), CLR_PRESS (KEY[1]=0), CLR_GAP (KEY[1]=1).
REQ-019 cmd_ready=1 only in IDLE with clr_req=0.
REQ-020 A command is accepted when cmd_valid and cmd_ready are both 1; operands are latched internally and input changes afterward are ignored.
REQ-021 Step order after accept:
  - a WRAP step with SW=A, only if ula_state==11;
  - A step: SW=A;
  - B step: SW=B;
  - OP step: SW[7:5]=op, SW[4:0]=0, Exib=exib.
REQ-022 Each step runs SETUP, then PRESS, then RELEASE; ula_state increments modulo 4 on the PRESS to RELEASE edge.
REQ-023 SW and Exib are constant throughout each step, including the press and the gap.
REQ-024 Timing without WRAP:
  - accept at cycle 0; SW=A from cycle 1;
  - first KEY[0] fall at cycle 1+SETTLE_CYCLES;
  - done at cycle 3*(SETTLE_CYCLES+PRESS_CYCLES+GAP_CYCLES)+1;
  - WRAP adds one more step period.
REQ-025 done pulses for exactly one cycle, then the FSM returns to IDLE with ula_state=11.
REQ-026 clr_req in IDLE:
  - runs CLR_PRESS for PRESS_CYCLES, then CLR_GAP for GAP_CYCLES;
  - sets ula_state=00 at the end of CLR_GAP;
  - pulses done.
REQ-027 cmd_valid and clr_req high together in IDLE: the clear wins and the command is not accepted.
REQ-028 clr_req while busy is ignored.
REQ-029 KEY[0] and KEY[1] are never low simultaneously.
REQ-030 busy=1 in every state except IDLE.
REQ-031 The hold counter is 24 bits, loads zero on each state entry, and each state exits when count==parameter-1.
REQ-032 A parameter value of 0 is treated as 1.

Reset
REQ-033 rst_n low asynchronously forces:
  - FSM to IDLE;
  - SW=0, Exib=0, KEY=11;
  - busy=0, done=0, cmd_ready=1;
  - ula_state=00;
  - counter=0.
REQ-034 Reset mid-press releases KEY within the same cycle that reset asserts; the in-flight command is discarded with no done.

Structure
REQ-035 Shared package ula_pkg holds:
  - the FSM state encoding;
  - ULA state codes (00 A, 01 B, 10 OP, 11 RESULT);
  - opcode constants (000 soma through 111 NOT);
  - exib codes.
REQ-036 Sub-module press_timer: 24-bit load/compare hold counter with a terminal-count output, instantiated once.

Verification (SETTLE=2, PRESS=4, GAP=3)
REQ-037 Reset, then command A=8'h05, B=8'h03, op=000 -> SW sequence 05, 03, 00; three KEY[0] pulses, each 4 cycles low; done at cycle 28; ula_state=11.
REQ-038 Second command A=8'h10, B=8'h02, op=001 -> WRAP press with SW=10, four pulses in total, done at cycle 37, ula_state=11.
REQ-039 Command with op=110, exib=10 -> during the OP step SW=8'hC0 and Exib=10.
REQ-040 cmd_valid and clr_req asserted together in IDLE -> only a KEY[1] pulse 4 cycles low, cmd_ready=0 throughout, done after 7 cycles, ula_state=00.
REQ-041 rst_n dropped during the second PRESS -> KEY=11 and SW=0 in the same cycle, no done, cmd_ready=1 after release.
REQ-042 clr_req pulsed during the B step -> ignored; sequence and done timing unchanged.
